ps2_game_cmd_decoder: RTL and testbench
=======================================

Name: ps2_game_cmd_decoder

Overview:
Converts the raw PS/2 byte stream from PS2_Controller (received_data / received_data_en) into per-command held levels and one-cycle command pulses for the Tetris FSMs.
- Replaces the "last byte received" register-and-compare scheme.
- Adds full make/break tracking and E0 extended-prefix decoding (real arrow keys).
- Adds parametrised auto-repeat (DAS) for movement commands.
- Sits between PS2_Controller and FSM_screen / FSM_Home / FSM_Gameplay.

Parameters:
CNT_W, 24, width of each repeat counter (must hold REPEAT_DELAY and REPEAT_PERIOD)
REPEAT_DELAY, 8000000, clocks from the initial make pulse to the first auto-repeat pulse (160 ms at 50 MHz)
REPEAT_PERIOD, 2500000, clocks between subsequent auto-repeat pulses (50 ms)
REPEAT_MASK, 9'b000000111, per-command auto-repeat enable (bit index = command index)

Ports:
CLOCK_50  input  1  system clock
reset  input  1  asynchronous, active-high reset
ps2_byte  input  8  received_data from PS2_Controller
ps2_byte_en  input  1  received_data_en; one-cycle strobe, ps2_byte valid
flush  input  1  synchronous clear of all held/repeat state (e.g. on mode change)
cmd_pulse  output  9  one-cycle command strobes
cmd_held  output  9  level: command key currently down
last_code  output  8  last non-prefix byte received (HEX display)
last_ext  output  1  last_code was E0-prefixed

Behaviour:
- Command index and scan-code mapping:
  - 0 left = E0 6B
  - 1 right = E0 74
  - 2 down = E0 72
  - 3 rotate = E0 75
  - 4 start = 5A
  - 5 gameover = 66
  - 6 easy = 16
  - 7 medium = 1E
  - 8 hard = 26
- Reset values: cmd_pulse = 0, cmd_held = 0, last_code = 00, last_ext = 0; prefix FSM in IDLE; all counters 0.
- Prefix FSM advances only on cycles with ps2_byte_en = 1.
  - State flags: IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 F0 seen).
  - IDLE: E0 -> EXT; F0 -> BRK; other -> make(code, ext=0), stay IDLE.
  - EXT: F0 -> EXTBRK; E0 -> stay EXT; other -> make(code, ext=1), -> IDLE.
  - BRK: any byte -> break(code, ext=0), -> IDLE.
  - EXTBRK: any byte -> break(code, ext=1), -> IDLE.
- On every make or break, last_code <= byte and last_ext <= ext. Prefix bytes E0/F0 never update last_code.
- Unmapped codes, including E1 pause sequences and E0 12 fake-shift, only update last_code/last_ext; they set no command.
- make on a mapped command i:
  - If cmd_held[i] = 0: set cmd_held[i], pulse cmd_pulse[i] the next cycle (latency 1 clock after the final byte's strobe), load counter i with REPEAT_DELAY.
  - If cmd_held[i] = 1 (keyboard typematic): ignored; no pulse, counter untouched.
- break on a mapped command i: clear cmd_held[i] and counter i. A break for a key not held has no effect.
- Auto-repeat, only for commands with REPEAT_MASK[i] = 1 while held:
  - Counter decrements each clock.
  - Reaching 1 produces a cmd_pulse[i] on the next cycle and reloads the counter with REPEAT_PERIOD.
  - First repeat pulse therefore occurs exactly REPEAT_DELAY clocks after the make pulse; later pulses every REPEAT_PERIOD clocks.
- A break arriving on the same cycle a repeat would fire suppresses that repeat pulse.
- cmd_pulse is never high for two consecutive cycles on the same bit when REPEAT_PERIOD >= 2. Multiple bits may pulse in the same cycle.
- flush = 1:
  - Clears cmd_held, all counters and cmd_pulse, and returns the FSM to IDLE.
  - A ps2_byte_en in the same cycle is discarded.
  - last_code and last_ext are retained.
- Asynchronous reset mid-sequence (e.g. after E0): returns to IDLE; the next byte is decoded as unprefixed.

Optional Feature:
PS2_WASD_ALIAS_EN
- Defined: unprefixed 1C/23/1B/1D (A/D/S/W) are aliases of left/right/down/rotate.
  - A command is held while either its arrow or its alias key is down (separate held bits internally, OR'd onto cmd_held).
  - Pulse and repeat trigger only on the first of the two to go down.
  - The command releases only when both keys are up.
- Undefined: those codes are unmapped; only the arrow keys drive commands 0-3.

Test Plan:
All cases below use bench parameters REPEAT_DELAY=10, REPEAT_PERIOD=4.
1. Bytes 5A, F0 5A -> cmd_pulse[4] high for exactly 1 cycle after the first strobe; cmd_held[4] high until the cycle after the break; last_code = 5A, last_ext = 0.
2. E0 6B, held 30 clocks, then E0 F0 6B -> pulse[0] at the make, repeats at +10, +14, +18, +22, +26; cmd_held[0] cleared after the break; last_ext = 1.
3. E0 75 sent 3 times (typematic), then E0 F0 75 -> exactly one pulse[3] and no repeats (mask bit 3 = 0).
4. E0, then reset asserted, then 6B -> no command (unprefixed 6B is unmapped); last_code = 6B, last_ext = 0.
5. E0 74 held; flush asserted at clock 5 together with a ps2_byte_en of 16 -> cmd_held = 0, no further pulse[1], no pulse[6].
6. With PS2_WASD_ALIAS_EN: 1C, then E0 6B, then F0 1C -> single pulse[0]; cmd_held[0] stays 1 until E0 F0 6B. Without the macro: 1C -> no pulse, last_code = 1C.

Source files
------------

// File: rtl/ps2_game_cmd_decoder.sv
// ps2_game_cmd_decoder: PS/2 scan-code stream to per-command held levels, make pulses and auto-repeat pulses
// Ports: CLOCK_50 clock; reset async active-high; ps2_byte/ps2_byte_en received byte strobe;
//        flush clears held/repeat state; cmd_pulse one-cycle strobes; cmd_held key-down levels;
//        last_code/last_ext last non-prefix byte and its E0 flag.
// Optional macro PS2_WASD_ALIAS_EN: unprefixed A/D/S/W also drive left/right/down/rotate.
module ps2_game_cmd_decoder #(
    parameter int         CNT_W         = 24,
    parameter int         REPEAT_DELAY  = 8000000,
    parameter int         REPEAT_PERIOD = 2500000,
    parameter logic [8:0] REPEAT_MASK   = 9'b000000111
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_en,
    input  logic       flush,
    output logic [8:0] cmd_pulse,
    output logic [8:0] cmd_held,
    output logic [7:0] last_code,
    output logic       last_ext
);
`ifdef PS2_WASD_ALIAS_EN
    localparam int NK = 13;
`else
    localparam int NK = 9;
`endif
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;
    state_t           state_q, state_d;
    logic [NK-1:0]    held_q, held_d;
    logic [8:0]       pulse_q, pulse_d;
    logic [7:0]       code_q, code_d;
    logic             ext_q, ext_d;
    logic [CNT_W-1:0] cnt_q [9];
    logic [CNT_W-1:0] cnt_d [9];
    logic             is_make, is_brk, is_ext, key_v;
    logic [3:0]       key, cmd;
    logic [8:0]       held_nx;

    // key ids 0-8 are the command keys themselves; 9-12 are the WASD aliases of commands 0-3
    function automatic logic [4:0] key_of(input logic e, input logic [7:0] b);
        case ({e, b})
            9'h16B:  return {1'b1, 4'd0};
            9'h174:  return {1'b1, 4'd1};
            9'h172:  return {1'b1, 4'd2};
            9'h175:  return {1'b1, 4'd3};
            9'h05A:  return {1'b1, 4'd4};
            9'h066:  return {1'b1, 4'd5};
            9'h016:  return {1'b1, 4'd6};
            9'h01E:  return {1'b1, 4'd7};
            9'h026:  return {1'b1, 4'd8};
`ifdef PS2_WASD_ALIAS_EN
            9'h01C:  return {1'b1, 4'd9};
            9'h023:  return {1'b1, 4'd10};
            9'h01B:  return {1'b1, 4'd11};
            9'h01D:  return {1'b1, 4'd12};
`endif
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [8:0] merge(input logic [NK-1:0] h);
`ifdef PS2_WASD_ALIAS_EN
        return h[8:0] | {5'd0, h[12:9]};
`else
        return h;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        pulse_d = '0;
        code_d  = code_q;
        ext_d   = ext_q;
        cnt_d   = cnt_q;
        is_make = 1'b0;
        is_brk  = 1'b0;
        is_ext  = 1'b0;
        // held repeat-enabled commands count down; reaching 1 fires a pulse and reloads the period
        for (int i = 0; i < 9; i++)
            if (REPEAT_MASK[i] && cmd_held[i] && cnt_q[i] != '0) begin
                pulse_d[i] = cnt_q[i] == CNT_W'(1);
                cnt_d[i]   = pulse_d[i] ? CNT_W'(REPEAT_PERIOD) : cnt_q[i] - CNT_W'(1);
            end
        if (ps2_byte_en)
            case (state_q)
                IDLE: begin
                    state_d = ps2_byte == 8'hE0 ? EXT : ps2_byte == 8'hF0 ? BRK : IDLE;
                    is_make = ps2_byte != 8'hE0 && ps2_byte != 8'hF0;
                end
                EXT: begin
                    state_d = ps2_byte == 8'hF0 ? EXTBRK : ps2_byte == 8'hE0 ? EXT : IDLE;
                    is_make = ps2_byte != 8'hE0 && ps2_byte != 8'hF0;
                    is_ext  = 1'b1;
                end
                BRK: begin
                    state_d = IDLE;
                    is_brk  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    is_brk  = 1'b1;
                    is_ext  = 1'b1;
                end
            endcase
        {key_v, key} = key_of(is_ext, ps2_byte);
        cmd = key >= 4'd9 ? key - 4'd9 : key;
        if (is_make || is_brk) begin
            code_d = ps2_byte;
            ext_d  = is_ext;
        end
        if (key_v && is_make) begin
            if (!cmd_held[cmd]) begin
                pulse_d[cmd] = 1'b1;
                cnt_d[cmd]   = CNT_W'(REPEAT_DELAY);
            end
            held_d[key] = 1'b1;
        end
        if (key_v && is_brk)
            held_d[key] = 1'b0;
        held_nx = merge(held_d);
        // a command dies (and its pending repeat with it) only once every key mapped to it is up
        for (int i = 0; i < 9; i++)
            if (cmd_held[i] && !held_nx[i]) begin
                pulse_d[i] = 1'b0;
                cnt_d[i]   = '0;
            end
        if (flush) begin
            state_d = IDLE;
            held_d  = '0;
            pulse_d = '0;
            code_d  = code_q;
            ext_d   = ext_q;
            cnt_d   = '{default: '0};
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            held_q  <= '0;
            pulse_q <= '0;
            code_q  <= '0;
            ext_q   <= 1'b0;
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            cnt_q   <= cnt_d;
        end

    assign cmd_pulse = pulse_q;
    assign cmd_held  = merge(held_q);
    assign last_code = code_q;
    assign last_ext  = ext_q;
endmodule

// File: tb/tb_ps2_game_cmd_decoder.sv
// tb_ps2_game_cmd_decoder: directed and randomized checks of the PS/2 command decoder against a key-down model
module tb_ps2_game_cmd_decoder;
    localparam int         D    = 10;
    localparam int         P    = 4;
    localparam logic [8:0] MASK = 9'b000000111;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, flush = 1'b0;
    logic [7:0] byte_i = 8'h00;
    logic [8:0] cmd_pulse, cmd_held;
    logic [7:0] last_code;
    logic       last_ext;
    int         checks = 0, errors = 0;

    ps2_game_cmd_decoder #(.CNT_W(8), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .REPEAT_MASK(MASK)) dut (
        .CLOCK_50(clk), .reset(rst), .ps2_byte(byte_i), .ps2_byte_en(en), .flush(flush),
        .cmd_pulse(cmd_pulse), .cmd_held(cmd_held), .last_code(last_code), .last_ext(last_ext)
    );

    always #5 clk = ~clk;

    logic [8:0] key_tab [9] = '{9'h16B, 9'h174, 9'h172, 9'h175, 9'h05A, 9'h066, 9'h016, 9'h01E, 9'h026};
`ifdef PS2_WASD_ALIAS_EN
    logic [8:0] alias_tab [4] = '{9'h01C, 9'h023, 9'h01B, 9'h01D};
`endif
    bit [511:0] down = '0;
    int         t0 [9] = '{default: 0};
    int         cyc = 0, el = 0, m_c = 0;
    bit         m_e0 = 1'b0, m_f0 = 1'b0;
    logic [8:0] m_pulse = '0, m_k = '0, exp_h = '0;
    logic [7:0] m_code = '0;
    logic       m_ext = 1'b0;
    int         npulse [9] = '{default: 0};
    logic [31:0] offs;
    int         b1, b6;
    logic [7:0] pool [14] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h5A, 8'h66, 8'h16, 8'h1E, 8'h26,
                              8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h12};

    // a command is down while any key mapped to it is down
    function automatic bit m_held(input int i);
        bit h = down[key_tab[i]];
`ifdef PS2_WASD_ALIAS_EN
        if (i < 4) h = h | down[alias_tab[i]];
`endif
        return h;
    endfunction

    function automatic int m_cmd(input logic [8:0] k);
        for (int i = 0; i < 9; i++) if (key_tab[i] == k) return i;
`ifdef PS2_WASD_ALIAS_EN
        for (int i = 0; i < 4; i++) if (alias_tab[i] == k) return i;
`endif
        return -1;
    endfunction

    // model: t0 is the cycle of a command's make pulse; repeats fall at t0+D, t0+D+P, ...
    always @(posedge clk) begin
        cyc++;
        m_pulse = '0;
        if (rst) begin
            down = '0; m_e0 = 1'b0; m_f0 = 1'b0; m_code = '0; m_ext = 1'b0;
        end else if (flush) begin
            down = '0; m_e0 = 1'b0; m_f0 = 1'b0;
        end else begin
            if (en) begin
                if (m_f0) begin
                    m_code = byte_i; m_ext = m_e0; m_k = {m_e0, byte_i};
                    m_e0 = 1'b0; m_f0 = 1'b0;
                    down[m_k] = 1'b0;
                end else if (byte_i == 8'hE0) m_e0 = 1'b1;
                else if (byte_i == 8'hF0) m_f0 = 1'b1;
                else begin
                    m_code = byte_i; m_ext = m_e0; m_k = {m_e0, byte_i}; m_e0 = 1'b0;
                    m_c = m_cmd(m_k);
                    if (m_c >= 0) begin
                        if (!m_held(m_c)) begin
                            t0[m_c] = cyc;
                            m_pulse[m_c] = 1'b1;
                        end
                        down[m_k] = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 9; i++)
                if (MASK[i] && m_held(i) && cyc > t0[i]) begin
                    el = cyc - t0[i];
                    if (el >= D && (el - D) % P == 0) m_pulse[i] = 1'b1;
                end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, a, e);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 9; i++) exp_h[i] = m_held(i);
            chk("cmd_pulse", cmd_pulse, m_pulse);
            chk("cmd_held", cmd_held, exp_h);
            chk("last_code", last_code, m_code);
            chk("last_ext", last_ext, m_ext);
            for (int i = 0; i < 9; i++) npulse[i] += cmd_pulse[i] ? 1 : 0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_i = b;
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("reset_pulse", cmd_pulse, 0);
        chk("reset_held", cmd_held, 0);
        chk("reset_code", last_code, 0);
        rst = 1'b0;
        tick(2);
        send(8'h5A);
        chk("t1_pulse", cmd_pulse, 9'h010);
        chk("t1_held", cmd_held, 9'h010);
        tick();
        chk("t1_pulse_once", cmd_pulse, 0);
        send(8'hF0);
        chk("t1_held_pre_break", cmd_held, 9'h010);
        send(8'h5A);
        chk("t1_held_after_break", cmd_held, 0);
        chk("t1_code", last_code, 8'h5A);
        chk("t1_ext", last_ext, 0);
        tick(3);
        send(8'hE0);
        send(8'h6B);
        chk("t2_make", cmd_pulse, 9'h001);
        offs = '0;
        for (int k = 1; k <= 29; k++) begin
            tick();
            if (cmd_pulse[0]) offs[k] = 1'b1;
        end
        chk("t2_repeat_offsets", offs, 32'h04444400);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        chk("t2_held", cmd_held, 0);
        chk("t2_ext", last_ext, 1);
        chk("t2_code", last_code, 8'h6B);
        tick(3);
        b1 = npulse[3];
        repeat (3) begin
            send(8'hE0);
            send(8'h75);
            tick(3);
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        tick(20);
        chk("t3_rotate_pulses", npulse[3] - b1, 1);
        chk("t3_held", cmd_held, 0);
        send(8'hE0);
        rst = 1'b1;
        tick();
        chk("t4_reset_held", cmd_held, 0);
        rst = 1'b0;
        send(8'h6B);
        chk("t4_pulse", cmd_pulse, 0);
        chk("t4_held", cmd_held, 0);
        chk("t4_code", last_code, 8'h6B);
        chk("t4_ext", last_ext, 0);
        send(8'hE0);
        send(8'h74);
        chk("t5_make", cmd_pulse, 9'h002);
        tick(4);
        byte_i = 8'h16;
        en = 1'b1;
        flush = 1'b1;
        tick();
        en = 1'b0;
        flush = 1'b0;
        chk("t5_held", cmd_held, 0);
        chk("t5_pulse", cmd_pulse, 0);
        b1 = npulse[1];
        b6 = npulse[6];
        tick(20);
        chk("t5_no_right", npulse[1] - b1, 0);
        chk("t5_no_easy", npulse[6] - b6, 0);
        chk("t5_code_kept", last_code, 8'h74);
        chk("t5_ext_kept", last_ext, 1);
`ifdef PS2_WASD_ALIAS_EN
        send(8'h1C);
        chk("t6_alias_make", cmd_pulse, 9'h001);
        send(8'hE0);
        send(8'h6B);
        chk("t6_arrow_no_pulse", cmd_pulse, 0);
        send(8'hF0);
        send(8'h1C);
        chk("t6_held_arrow", cmd_held, 9'h001);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        chk("t6_released", cmd_held, 0);
`else
        send(8'h1C);
        chk("t6_no_pulse", cmd_pulse, 0);
        chk("t6_no_held", cmd_held, 0);
        chk("t6_code", last_code, 8'h1C);
`endif
        tick(3);
        repeat (500) begin
            case ($urandom_range(0, 99)) inside
                [0:1]: begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                end
                [2:6]: begin
                    byte_i = 8'($urandom);
                    en = 1'($urandom_range(0, 1));
                    flush = 1'b1;
                    tick();
                    flush = 1'b0;
                    en = 1'b0;
                end
                [7:10]: send(8'($urandom));
                default: begin
                    if ($urandom_range(0, 2) != 0) send(8'hE0);
                    if ($urandom_range(0, 1) != 0) send(8'hF0);
                    send(pool[$urandom_range(0, 13)]);
                end
            endcase
            tick($urandom_range(0, 12));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
